// File: rtl/eq_pair_checker.sv
// Streaming equality checker: consumes A/B operand pairs, emits one eq result per pair
// with its run index, and keeps saturating match/mismatch counts plus the first-mismatch index.
module eq_pair_checker #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic [CNT_W-1:0] out_idx,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mis_valid,
  output logic [CNT_W-1:0] first_mis_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_eq_q, out_eq_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             first_mis_valid_q, first_mis_valid_d;
  logic [CNT_W-1:0] first_mis_idx_q, first_mis_idx_d;

  logic accept;
  logic out_hs;
  logic pair_eq;

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign pair_eq  = (in_a == in_b);

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    out_valid_d       = out_valid_q;
    out_eq_d          = out_eq_q;
    out_idx_d         = out_idx_q;
    match_cnt_d       = match_cnt_q;
    mismatch_cnt_d    = mismatch_cnt_q;
    first_mis_valid_d = first_mis_valid_q;
    first_mis_idx_d   = first_mis_idx_q;

    // A new acceptance takes priority over draining, so a same-cycle handshake leaves no bubble.
    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_eq_d    = pair_eq;
      out_idx_d   = idx_q;
      idx_d       = idx_q + 1'b1;
      if (pair_eq) begin
        if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
      end else begin
        if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        if (!first_mis_valid_q) begin
          first_mis_valid_d = 1'b1;
          first_mis_idx_d   = idx_q;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d             = '0;
          match_cnt_d       = '0;
          mismatch_cnt_d    = '0;
          first_mis_valid_d = 1'b0;
          first_mis_idx_d   = '0;
          state_d           = RUN;
        end
      end
      RUN: begin
        if (accept && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!out_valid_q || out_hs) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      out_valid_q       <= 1'b0;
      out_eq_q          <= 1'b0;
      out_idx_q         <= '0;
      match_cnt_q       <= '0;
      mismatch_cnt_q    <= '0;
      first_mis_valid_q <= 1'b0;
      first_mis_idx_q   <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      out_valid_q       <= out_valid_d;
      out_eq_q          <= out_eq_d;
      out_idx_q         <= out_idx_d;
      match_cnt_q       <= match_cnt_d;
      mismatch_cnt_q    <= mismatch_cnt_d;
      first_mis_valid_q <= first_mis_valid_d;
      first_mis_idx_q   <= first_mis_idx_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_eq          = out_eq_q;
  assign out_idx         = out_idx_q;
  assign match_cnt       = match_cnt_q;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_mis_valid = first_mis_valid_q;
  assign first_mis_idx   = first_mis_idx_q;
  assign busy            = (state_q == RUN) || (state_q == FLUSH);
  assign done            = (state_q == DONE);

endmodule
